// File: rtl/uni_shift_reg_p.sv
// uni_shift_reg_p: universal shift register with single-step and burst modes.
// Single-step ops apply one mode operation per enabled edge while idle. A
// burst latches a shift mode and a length N, then performs N shifts on
// consecutive edges and pulses done on the final one.
// Optional feature macro: UNI_SR_ROTATE_EN enables rotates for modes 101/110.
// Without it those modes hold, and a burst request with them is degenerate.
module uni_shift_reg_p #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ASR  = 3'b100;
`ifdef UNI_SR_ROTATE_EN
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
`endif
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_mode;
    logic [2:0]       w_mode_nxt;
    logic             r_done;
    logic             w_done_nxt;

    // Next register value for one operation of the given mode.
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [2:0]       md,
        input logic [WIDTH-1:0] v,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH-1:0] res;
        res = v;
        case (md)
            MODE_HOLD: res = v;
            MODE_SHL:  res = {v[WIDTH-2:0], sl};
            MODE_SHR:  res = {sr, v[WIDTH-1:1]};
            MODE_LOAD: res = p;
            MODE_ASR:  res = {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef UNI_SR_ROTATE_EN
            MODE_ROL:  res = {v[WIDTH-2:0], v[WIDTH-1]};
            MODE_ROR:  res = {v[0], v[WIDTH-1:1]};
`endif
            MODE_CLR:  res = '0;
            default:   res = v;
        endcase
        return res;
    endfunction

    // True for modes that may be repeated as a burst.
    function automatic logic f_is_shift(input logic [2:0] md);
        logic ok;
        ok = (md == MODE_SHL) || (md == MODE_SHR) || (md == MODE_ASR);
`ifdef UNI_SR_ROTATE_EN
        ok = ok || (md == MODE_ROL) || (md == MODE_ROR);
`endif
        return ok;
    endfunction

    // Next-state and datapath decode; start wins over en while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ((burst_len != '0) && f_is_shift(mode)) begin
                        w_state_nxt = ST_BURST;
                        w_cnt_nxt   = burst_len;
                        w_mode_nxt  = mode;
                    end else begin
                        // Degenerate request: acknowledge without shifting.
                        w_done_nxt = 1'b1;
                    end
                end else if (en) begin
                    w_q_nxt = f_shift(mode, r_q, sin_l, sin_r, pin);
                end
            end
            ST_BURST: begin
                // Serial inputs are taken live each burst edge.
                w_q_nxt   = f_shift(r_mode, r_q, sin_l, sin_r, pin);
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, data and burst bookkeeping registers with async active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_HOLD;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = (r_state == ST_BURST);
    assign done   = r_done;

endmodule

// File: tb/tb_uni_shift_reg_p.sv
// Testbench for uni_shift_reg_p (WIDTH=8, CNT_W=4): directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_uni_shift_reg_p;

    localparam int W = 8;
    localparam int CW = 4;
`ifdef UNI_SR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic [W-1:0]  pin = '0;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    uni_shift_reg_p #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l),
        .sin_r(sin_r), .pin(pin), .start(start), .burst_len(burst_len),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] m_q = 8'h00;
    int         m_rem = 0;
    logic [2:0] m_mode = 3'd0;
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;

    function automatic logic [7:0] m_apply(input logic [2:0] md, input int v,
                                           input int sl, input int sr, input int p);
        int x;
        case (md)
            3'd1: x = (v * 2 + sl) % 256;
            3'd2: x = v / 2 + sr * 128;
            3'd3: x = p % 256;
            3'd4: x = v / 2 + ((v >= 128) ? 128 : 0);
            3'd5: x = ROT ? ((v * 2) % 256 + v / 128) : v;
            3'd6: x = ROT ? (v / 2 + (v % 2) * 128) : v;
            3'd7: x = 0;
            default: x = v;
        endcase
        return x[7:0];
    endfunction

    function automatic bit m_shift_ok(input logic [2:0] md);
        return (md == 3'd1) || (md == 3'd2) || (md == 3'd4) ||
               (ROT && ((md == 3'd5) || (md == 3'd6)));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q <= 8'h00; m_rem <= 0; m_mode <= 3'd0; m_busy <= 1'b0; m_done <= 1'b0;
        end else if (m_busy) begin
            m_q    <= m_apply(m_mode, int'(m_q), int'(sin_l), int'(sin_r), int'(pin));
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            m_busy <= (m_rem != 1);
        end else if (start) begin
            if (burst_len != 0 && m_shift_ok(mode)) begin
                m_busy <= 1'b1; m_rem <= int'(burst_len); m_mode <= mode; m_done <= 1'b0;
            end else begin
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (en) m_q <= m_apply(mode, int'(m_q), int'(sin_l), int'(sin_r), int'(pin));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q", 32'(q), 32'(m_q));
            chk("model_sout_l", 32'(sout_l), 32'(m_q[7]));
            chk("model_sout_r", 32'(sout_r), 32'(m_q[0]));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sout", 32'({sout_l, sout_r}), 32'h0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Parallel load
        en = 1'b1; mode = 3'b011; pin = 8'hA5;
        cyc();
        chk("load_q", 32'(q), 32'hA5);
        chk("load_model_q", 32'(m_q), 32'hA5);
        chk("load_sout_l", 32'(sout_l), 32'h1);
        chk("load_sout_r", 32'(sout_r), 32'h1);

        // Arithmetic shift right sequence
        mode = 3'b100;
        cyc(); chk("asr1_q", 32'(q), 32'hD2);
        cyc(); chk("asr2_q", 32'(q), 32'hE9);
        chk("asr2_model_q", 32'(m_q), 32'hE9);
        cyc(); chk("asr3_q", 32'(q), 32'hF4);

        // Rotate-left burst of 3 from 0x81
        mode = 3'b011; pin = 8'h81;
        cyc();
        en = 1'b0; mode = 3'b101; start = 1'b1; burst_len = 4'd3;
        cyc();
        start = 1'b0;
`ifdef UNI_SR_ROTATE_EN
        chk("rol_busy0", 32'(busy), 32'h1);
        chk("rol_q0", 32'(q), 32'h81);
        cyc(); chk("rol_busy1", 32'(busy), 32'h1); chk("rol_q1", 32'(q), 32'h03);
        cyc(); chk("rol_busy2", 32'(busy), 32'h1); chk("rol_q2", 32'(q), 32'h06);
        cyc();
        chk("rol_q3", 32'(q), 32'h0C);
        chk("rol_model_q3", 32'(m_q), 32'h0C);
        chk("rol_done", 32'(done), 32'h1);
        chk("rol_busy3", 32'(busy), 32'h0);
`else
        chk("rol_off_busy", 32'(busy), 32'h0);
        chk("rol_off_q", 32'(q), 32'h81);
        chk("rol_off_done", 32'(done), 32'h1);
`endif
        cyc();
        chk("rol_done_clear", 32'(done), 32'h0);

        // Logical right burst of 4 from 0xFF, mode/en disturbed mid-burst
        en = 1'b1; mode = 3'b011; pin = 8'hFF;
        cyc();
        en = 1'b0; mode = 3'b010; sin_r = 1'b0; start = 1'b1; burst_len = 4'd4;
        cyc();
        start = 1'b0; mode = 3'b111; en = 1'b1;
        chk("shr_busy0", 32'(busy), 32'h1);
        chk("shr_q0", 32'(q), 32'hFF);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("shr_busy_mid", 32'(busy), 32'h1);
        end
        cyc();
        en = 1'b0;
        chk("shr_q_done", 32'(q), 32'h0F);
        chk("shr_done", 32'(done), 32'h1);
        chk("shr_busy_end", 32'(busy), 32'h0);

        // Reset mid-burst, then a length-1 burst
        en = 1'b1; mode = 3'b011; pin = 8'h3C;
        cyc();
        en = 1'b0; mode = 3'b001; sin_l = 1'b1; start = 1'b1; burst_len = 4'd5;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        chk("abort_pre_q", 32'(q), 32'hF3);
        chk("abort_pre_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_sout", 32'({sout_l, sout_r}), 32'h0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("abort_no_done", 32'(done), 32'h0);
        end
        en = 1'b1; mode = 3'b011; pin = 8'h5A;
        cyc();
        en = 1'b0; mode = 3'b001; sin_l = 1'b0; start = 1'b1; burst_len = 4'd1;
        cyc();
        start = 1'b0;
        chk("b1_busy", 32'(busy), 32'h1);
        cyc();
        chk("b1_q", 32'(q), 32'hB4);
        chk("b1_done", 32'(done), 32'h1);
        chk("b1_busy_end", 32'(busy), 32'h0);

        // Degenerate starts
        mode = 3'b001; start = 1'b1; burst_len = 4'd0;
        cyc();
        start = 1'b0;
        chk("deg0_q", 32'(q), 32'hB4);
        chk("deg0_busy", 32'(busy), 32'h0);
        chk("deg0_done", 32'(done), 32'h1);
        cyc();
        chk("deg0_done_clear", 32'(done), 32'h0);
`ifndef UNI_SR_ROTATE_EN
        mode = 3'b101; start = 1'b1; burst_len = 4'd2;
        cyc();
        start = 1'b0;
        chk("deg5_q", 32'(q), 32'hB4);
        chk("deg5_busy", 32'(busy), 32'h0);
        chk("deg5_done", 32'(done), 32'h1);
        cyc();
        chk("deg5_done_clear", 32'(done), 32'h0);
`endif

        // Back-to-back bursts with start held high
        mode = 3'b001; sin_l = 1'b1; start = 1'b1; burst_len = 4'd2;
        cyc();
        cyc(); chk("bb_q1", 32'(q), 32'h69); chk("bb_busy1", 32'(busy), 32'h1);
        cyc(); chk("bb_q2", 32'(q), 32'hD3); chk("bb_done1", 32'(done), 32'h1);
        mode = 3'b010; sin_r = 1'b1; burst_len = 4'd1;
        cyc();
        start = 1'b0;
        chk("bb_busy_again", 32'(busy), 32'h1);
        cyc();
        chk("bb_q3", 32'(q), 32'hE9);
        chk("bb_done2", 32'(done), 32'h1);

        // Randomized traffic checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            en = 1'($urandom_range(0, 1));
            mode = 3'($urandom_range(0, 7));
            sin_l = 1'($urandom_range(0, 1));
            sin_r = 1'($urandom_range(0, 1));
            pin = 8'($urandom);
            start = ($urandom_range(0, 3) == 0);
            burst_len = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rst = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst = 1'b1; start = 1'b0; en = 1'b0;
        repeat (20) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
